// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, read-word
// bit positions and the baud divider helper.
package uart_pkg;

  // Receiver FSM state encoding.
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;
  localparam logic [2:0] StBreak  = 3'd5;

  // Bit positions inside the 10-bit read word.
  localparam int unsigned ERR_BIT   = 9;
  localparam int unsigned AVAIL_BIT = 8;

  // Clocks per bit, rounded to nearest, floored at 4 so the half-bit count
  // and the synchroniser delay still leave a usable sample window.
  function automatic int unsigned bit_ticks(input int unsigned clk_hz,
                                            input int unsigned baud);
    int unsigned t;
    t = (clk_hz + baud / 2) / baud;
    if (t < 4) t = 4;
    return t;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head/avail outputs that already reflect
// the push/pop of the current cycle, so readers see new data one clock later.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             avail,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW  = AW + 1;
  localparam int unsigned Depth = 2 ** AW;

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [Depth];
  logic [WIDTH-1:0] head_q, head_d;
  logic             avail_q, avail_d;
  logic             push_en, pop_en;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);

  // Next pointers and the look-ahead head (bypass when the new head slot is being written).
  always_comb begin
    wptr_d  = wptr_q + PtrW'(push_en);
    rptr_d  = rptr_q + PtrW'(pop_en);
    avail_d = (wptr_d != rptr_d);
    if (!avail_d) begin
      head_d = '0;
    end else if (push_en && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
      head_d = wdata;
    end else begin
      head_d = mem_q[rptr_d[AW-1:0]];
    end
  end

  // Pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      head_q  <= '0;
      avail_q <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      head_q  <= head_d;
      avail_q <= avail_d;
    end
  end

  // Storage array; contents are only visible through head, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign avail = avail_q;
  assign head  = head_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchroniser, mid-bit sampling deserialiser, receive FIFO
// and sticky error flag, presented as {err, rx_avail, head_byte}.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned BAUD    = 115200,
  parameter int unsigned FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  input  logic       cpu_sel,
  input  logic       cpu_wr,
  input  logic       rd_ack,
  output logic [9:0] dout,
  output logic       rx_irq
);

  import uart_pkg::*;

  localparam int unsigned BIT_TICKS  = bit_ticks(CLK_HZ, BAUD);
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam int unsigned CntW       = $clog2(BIT_TICKS + 1);

  logic            rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            err_q, err_d;
  logic            tick, push_req, frame_err, overrun, new_err;
  logic            fifo_full, fifo_empty, fifo_avail, pop_eff;
  logic [7:0]      fifo_head;
`ifdef UART_RX_PARITY_EN
  logic            par_err_q, par_err_d, par_err_set;
`endif

  // Synchroniser flops idle high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign tick = (cnt_q == CntW'(1));

  // Deserialiser next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d   = par_err_q;
    par_err_set = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          cnt_d   = CntW'(HALF_TICKS);
          state_d = StStart;
        end
      end
      StStart: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rxd_sync_q) begin
          state_d = StIdle;
        end else begin
          cnt_d     = CntW'(BIT_TICKS);
          bit_idx_d = 3'd0;
          state_d   = StData;
`ifdef UART_RX_PARITY_EN
          par_err_d = 1'b0;
`endif
        end
      end
      StData: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          shift_d = {rxd_sync_q, shift_q[7:1]};
          cnt_d   = CntW'(BIT_TICKS);
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          // Even parity: data plus parity bit must XOR to zero.
          par_err_d   = ^{shift_q, rxd_sync_q};
          par_err_set = par_err_d;
          cnt_d       = CntW'(BIT_TICKS);
          state_d     = StStop;
        end
      end
`endif
      StStop: begin
        if (!tick) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (rxd_sync_q) begin
`ifdef UART_RX_PARITY_EN
          push_req = !par_err_q;
`else
          push_req = 1'b1;
`endif
          state_d = StIdle;
        end else begin
          frame_err = 1'b1;
          state_d   = StBreak;
        end
      end
      StBreak: begin
        // Hold here while the line is low so a long break reports one error.
        if (rxd_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Deserialiser state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign pop_eff = rd_ack && !fifo_empty;
  assign overrun = push_req && fifo_full && !pop_eff;

`ifdef UART_RX_PARITY_EN
  assign new_err = frame_err || overrun || par_err_set;
`else
  assign new_err = frame_err || overrun;
`endif

  // Sticky error: CPU write clears it, a same-cycle new error takes priority.
  always_comb begin
    err_d = err_q;
    if (cpu_sel && cpu_wr) err_d = 1'b0;
    if (new_err)           err_d = 1'b1;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata (shift_q),
    .pop   (rd_ack),
    .full  (fifo_full),
    .empty (fifo_empty),
    .avail (fifo_avail),
    .head  (fifo_head)
  );

  assign dout[ERR_BIT]   = err_q;
  assign dout[AVAIL_BIT] = fifo_avail;
  assign dout[7:0]       = fifo_head;
  assign rx_irq          = fifo_avail || err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 10 clocks per bit; received bytes are checked
// against a scoreboard queue filled when each frame is driven.
module tb_uart_rx;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       rxd     = 1'b1;
  logic       cpu_sel = 1'b0;
  logic       cpu_wr  = 1'b0;
  logic       rd_ack  = 1'b0;
  logic [9:0] dout;
  logic       rx_irq;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [7:0]  exp_q[$];

  uart_rx #(
    .CLK_HZ  (1000000),
    .BAUD    (100000),
    .FIFO_AW (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rxd     (rxd),
    .cpu_sel (cpu_sel),
    .cpu_wr  (cpu_wr),
    .rd_ack  (rd_ack),
    .dout    (dout),
    .rx_irq  (rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish expected finish before 3 ms");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rxd = b;
    tick(n);
  endtask

  // mode 0: plain; 1: check stop-sample latency; 2: pulse rd_ack on the push cycle.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int mode);
    drive_bit(1'b0, 10);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 10);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d, 10);
`endif
    rxd = stop;
    tick(7);
    if (mode == 1) check("pre_push_avail", {9'b0, dout[8]}, 10'h000);
    if (mode == 2) begin
      check("ack_at_push_head", dout, {2'b01, exp_q.pop_front()});
      rd_ack = 1'b1;
    end
    tick(1);
    rd_ack = 1'b0;
    if (mode == 1) check("latency_dout", dout, {2'b01, d});
    tick(2);
  endtask

  // Wait (bounded) for a byte, compare against the scoreboard head, then pop it.
  task automatic read_check(input string tag);
    int         waited;
    logic [7:0] exp;
    waited = 0;
    while (!dout[8] && waited < 300) begin
      tick(1);
      waited++;
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
    check(tag, {1'b0, dout[8:0]}, {2'b01, exp});
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  task automatic cpu_write(input logic wr);
    cpu_sel = 1'b1;
    cpu_wr  = wr;
    tick(1);
    cpu_sel = 1'b0;
    cpu_wr  = 1'b0;
  endtask

  initial begin
    tick(3);
    check("reset_dout", dout, 10'h000);
    check("reset_irq", {9'b0, rx_irq}, 10'h000);
    rst_n = 1'b1;
    tick(5);

    // Single byte with latency check, then pop.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1);
    check("a5_irq", {9'b0, rx_irq}, 10'h001);
    read_check("a5_read");
    check("a5_popped_dout", dout, 10'h000);
    check("a5_popped_irq", {9'b0, rx_irq}, 10'h000);

    // Short low glitch must be rejected by the start-bit check.
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 40);
    check("glitch_dout", dout, 10'h000);

    // Framing error followed by a long break: one error, nothing pushed.
    send_frame(8'h3C, 1'b0, 0);
    drive_bit(1'b0, 300);
    drive_bit(1'b1, 20);
    check("frame_err_dout", dout, 10'h200);
    check("frame_err_irq", {9'b0, rx_irq}, 10'h001);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 0);
    check("err_sticky_dout", dout, 10'h311);
    cpu_write(1'b0);
    check("sel_no_wr_keeps_err", dout, 10'h311);
    cpu_write(1'b1);
    check("err_clear_dout", dout, 10'h111);
    read_check("b11_read");

    // Overrun: 17 bytes into a 16-deep FIFO.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 0);
      if (i == 15) check("full_no_err", dout, 10'h100);
    end
    check("overrun_dout", dout, 10'h300);
    for (int i = 0; i < 16; i++) read_check("overrun_read");
    check("overrun_drained", dout, 10'h200);
    cpu_write(1'b1);
    check("overrun_cleared", dout, 10'h000);

    // Push and pop in the same cycle while full.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      send_frame(8'h80 + 8'(i), 1'b1, 0);
    end
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 2);
    check("simul_no_err", {9'b0, dout[9]}, 10'h000);
    for (int i = 0; i < 16; i++) read_check("simul_read");
    check("simul_drained", dout, 10'h000);

    // Reset in the middle of a frame with a byte already buffered.
    send_frame(8'h77, 1'b1, 0);
    drive_bit(1'b0, 10);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 10);
    drive_bit(1'b1, 5);
    rst_n = 1'b0;
    #1;
    check("midframe_reset_dout", dout, 10'h000);
    check("midframe_reset_irq", {9'b0, rx_irq}, 10'h000);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    check("post_reset_idle", dout, 10'h000);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1, 0);
    read_check("b42_read");

`ifdef UART_RX_PARITY_EN
    // Bad parity bit (odd overall) on 8'h03: error, no push.
    drive_bit(1'b0, 10);
    for (int i = 0; i < 8; i++) drive_bit(i < 2, 10);
    drive_bit(1'b1, 10);
    drive_bit(1'b1, 12);
    check("parity_err_dout", dout, 10'h200);
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 0);
    check("parity_ok_dout", dout, 10'h303);
    read_check("b03_read");
`endif

    check("scoreboard_empty", 10'(exp_q.size()), 10'h000);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
